// File: rtl/johnson_ctr_param.sv
// Parametrised Johnson (twisted-ring) counter with scan shift, up/down stepping, phase load,
// illegal-state detection/self-correction, decoded phase index and a wrap pulse.
module johnson_ctr_param #(
    parameter int WIDTH        = 8,
    parameter bit SELF_CORRECT = 1'b1,
    localparam int PW          = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [PW-1:0]    load_phase,
    input  logic             SE,
    input  logic             SCANINPORT,
    output logic [0:WIDTH-1] out,
    output logic [PW-1:0]    phase,
    output logic             tc,
    output logic             illegal,
    output logic             SCANOUTPORT
);

    logic [0:WIDTH-1] state_q;
    logic [0:WIDTH-1] state_d;
    int               n_edges;
    int               ones;

    // Johnson code of phase k; indices outside 0..2W-1 map to phase 0 (all zero).
    function automatic logic [0:WIDTH-1] encode(input logic [PW-1:0] k);
        logic [0:WIDTH-1] v;
        int               kk;
        kk = int'(k);
        v  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (kk <= WIDTH)
                v[i] = (i < kk);
            else if (kk < 2*WIDTH)
                v[i] = (i >= kk - WIDTH);
        end
        return v;
    endfunction

    // A legal Johnson code has at most one boundary between adjacent ring bits.
    always_comb begin
        n_edges = 0;
        for (int i = 0; i < WIDTH-1; i++)
            n_edges = n_edges + ((state_q[i] != state_q[i+1]) ? 1 : 0);
        illegal = (n_edges > 1);
    end

    // For legal codes the phase follows from the population count and out[0].
    always_comb begin
        ones = 0;
        for (int i = 0; i < WIDTH; i++)
            ones = ones + int'(state_q[i]);
        if (illegal)
            phase = '0;
        else if (state_q[0])
            phase = PW'(ones);
        else if (ones == 0)
            phase = '0;
        else
            phase = PW'(2*WIDTH - ones);
    end

    always_comb begin
        tc = en && !SE && !load && !illegal &&
             ((!dir && (phase == PW'(2*WIDTH-1))) || (dir && (phase == '0)));
    end

    always_comb begin
        state_d = state_q;
        if (SE)
            state_d = {SCANINPORT, state_q[0:WIDTH-2]};
        else if (load)
            state_d = encode(load_phase);
        else if (illegal && SELF_CORRECT)
            state_d = '0;
        else if (en && !dir)
            state_d = {~state_q[WIDTH-1], state_q[0:WIDTH-2]};
        else if (en && dir)
            state_d = {state_q[1:WIDTH-1], ~state_q[0]};
    end

    always_ff @(posedge clk or posedge r) begin
        if (r)
            state_q <= '0;
        else
            state_q <= state_d;
    end

    assign out         = state_q;
    assign SCANOUTPORT = state_q[WIDTH-1];

endmodule

// File: tb/tb_johnson_ctr_param.sv
// Randomised and directed bench for johnson_ctr_param: three instances (W=8 self-correcting,
// W=3 self-correcting, W=8 free-running) checked against a phase-level reference model.
module tb_johnson_ctr_param;

    logic       clk = 1'b0;
    logic       r = 1'b1;
    logic       en = 1'b0, dir = 1'b0, load = 1'b0, SE = 1'b0, SCANINPORT = 1'b0;
    logic [3:0] lp8 = '0;
    logic [2:0] lp3 = '0;

    logic [0:7] out8, out8n;
    logic [0:2] out3;
    logic [3:0] ph8, ph8n;
    logic [2:0] ph3;
    logic       tc8, tc8n, tc3, il8, il8n, il3, so8, so8n, so3;

    bit [15:0] g8, g8n, g3;
    bit [15:0] m8, m8n, m3;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    johnson_ctr_param #(.WIDTH(8), .SELF_CORRECT(1'b1)) u8 (
        .clk(clk), .r(r), .en(en), .dir(dir), .load(load), .load_phase(lp8), .SE(SE),
        .SCANINPORT(SCANINPORT), .out(out8), .phase(ph8), .tc(tc8), .illegal(il8),
        .SCANOUTPORT(so8));

    johnson_ctr_param #(.WIDTH(8), .SELF_CORRECT(1'b0)) u8n (
        .clk(clk), .r(r), .en(en), .dir(dir), .load(load), .load_phase(lp8), .SE(SE),
        .SCANINPORT(SCANINPORT), .out(out8n), .phase(ph8n), .tc(tc8n), .illegal(il8n),
        .SCANOUTPORT(so8n));

    johnson_ctr_param #(.WIDTH(3), .SELF_CORRECT(1'b1)) u3 (
        .clk(clk), .r(r), .en(en), .dir(dir), .load(load), .load_phase(lp3), .SE(SE),
        .SCANINPORT(SCANINPORT), .out(out3), .phase(ph3), .tc(tc3), .illegal(il3),
        .SCANOUTPORT(so3));

    always_comb begin
        g8 = '0; g8n = '0; g3 = '0;
        for (int i = 0; i < 8; i++) begin
            g8[i]  = out8[i];
            g8n[i] = out8n[i];
        end
        for (int i = 0; i < 3; i++) g3[i] = out3[i];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---- reference model: bit b[i] mirrors out[i] ----
    function automatic bit m_illegal(bit [15:0] b, int w);
        int n = 0;
        for (int i = 0; i < w-1; i++) if (b[i] != b[i+1]) n++;
        return n > 1;
    endfunction

    function automatic int m_phase(bit [15:0] b, int w);
        int c = 0;
        if (m_illegal(b, w)) return 0;
        if (b[0]) begin
            while (c < w && b[c]) c++;
            return c;
        end
        while (c < w && !b[c]) c++;
        return (c == w) ? 0 : w + c;
    endfunction

    function automatic bit [15:0] m_enc(int k, int w);
        bit [15:0] v = '0;
        if (k >= 2*w) k = 0;
        for (int i = 0; i < w; i++) v[i] = (k <= w) ? (i < k) : (i >= k - w);
        return v;
    endfunction

    function automatic bit [15:0] m_mask(bit [15:0] b, int w);
        for (int i = w; i < 16; i++) b[i] = 1'b0;
        return b;
    endfunction

    function automatic bit [15:0] m_next(bit [15:0] b, int w, bit sc, int lp);
        bit [15:0] nb;
        if (SE) begin
            nb = b << 1;
            nb[0] = SCANINPORT;
            return m_mask(nb, w);
        end
        if (load) return m_enc(lp, w);
        if (m_illegal(b, w) && sc) return '0;
        if (!en) return b;
        if (!m_illegal(b, w))
            return m_enc((m_phase(b, w) + (dir ? 2*w-1 : 1)) % (2*w), w);
        if (!dir) begin
            nb = b << 1;
            nb[0] = ~b[w-1];
        end else begin
            nb = b >> 1;
            nb[w-1] = ~b[0];
        end
        return m_mask(nb, w);
    endfunction

    function automatic bit m_tc(bit [15:0] b, int w);
        int p = m_phase(b, w);
        return en && !SE && !load && !m_illegal(b, w) &&
               ((!dir && p == 2*w-1) || (dir && p == 0));
    endfunction

    task automatic check_inst(input string nm, input bit [15:0] got, input int gph,
                              input logic gtc, input logic gil, input logic gso,
                              input bit [15:0] m, input int w);
        check({nm, ".out"}, int'(got), int'(m));
        check({nm, ".phase"}, gph, m_phase(m, w));
        check({nm, ".illegal"}, int'(gil), int'(m_illegal(m, w)));
        check({nm, ".tc"}, int'(gtc), int'(m_tc(m, w)));
        check({nm, ".scanout"}, int'(gso), int'(m[w-1]));
    endtask

    task automatic check_all();
        check_inst("u8", g8, int'(ph8), tc8, il8, so8, m8, 8);
        check_inst("u8n", g8n, int'(ph8n), tc8n, il8n, so8n, m8n, 8);
        check_inst("u3", g3, int'(ph3), tc3, il3, so3, m3, 3);
    endtask

    task automatic tick();
        @(posedge clk);
        m8  = m_next(m8, 8, 1'b1, int'(lp8));
        m8n = m_next(m8n, 8, 1'b0, int'(lp8));
        m3  = m_next(m3, 3, 1'b1, int'(lp3));
        #1;
        check_all();
    endtask

    task automatic do_reset();
        r = 1'b1;
        #1;
        m8 = '0; m8n = '0; m3 = '0;
        check_all();
        r = 1'b0;
    endtask

    task automatic set_lp(input int v);
        lp8 = 4'(v);
        lp3 = 3'(v);
    endtask

    initial begin
        bit [7:0] sbits;
        bit       so_exp [8];
        m8 = '0; m8n = '0; m3 = '0;
        #12;
        check_all();
        check("rst.phase", int'(ph8), 0);
        check("rst.tc", int'(tc8), 0);
        r = 1'b0;

        // T1: count up through a full 16-state wrap
        en = 1'b1; dir = 1'b0;
        repeat (8) tick();
        check("t1.ones", int'(g8), 'hFF);
        check("t1.ph8", int'(ph8), 8);
        repeat (7) tick();
        check("t1.ph15", int'(ph8), 15);
        check("t1.tc", int'(tc8), 1);
        tick();
        check("t1.wrap", int'(g8), 0);

        // T2: count down from phase 0
        do_reset();
        en = 1'b1; dir = 1'b1;
        #1;
        check("t2.tc_pre", int'(tc8), 1);
        tick();
        check("t2.out1", int'(g8), 'h80);
        check("t2.ph15", int'(ph8), 15);
        tick();
        check("t2.out2", int'(g8), 'hC0);
        check("t2.ph14", int'(ph8), 14);

        // T3: loads, including an out-of-range index on the W=3 instance
        en = 1'b0; load = 1'b1;
        set_lp(5); tick();
        check("t3.ld5", int'(g8), 'h1F);
        set_lp(12); tick();
        check("t3.ld12", int'(g8), 'hF0);
        check("t3.ph12", int'(ph8), 12);
        set_lp(6); tick();
        check("t3.w3_oob", int'(g3), 0);
        SE = 1'b1; SCANINPORT = 1'b1; tick();
        check("t3.scan_wins", int'(g8), 'h7F);
        load = 1'b0; SE = 1'b0;

        // T4: scan an illegal pattern in, then self-correct (or not)
        do_reset();
        SE = 1'b1; sbits = 8'b1010_0000;
        for (int i = 7; i >= 0; i--) begin
            SCANINPORT = sbits[i];
            tick();
        end
        SE = 1'b0; SCANINPORT = 1'b0; en = 1'b0;
        #1;
        check("t4.illegal", int'(il8), 1);
        check("t4.phase", int'(ph8), 0);
        tick();
        check("t4.fixed", int'(g8), 0);
        check("t4.nofix", int'(il8n), 1);
        en = 1'b1; dir = 1'b0;
        tick();
        check("t4.nofix_step", int'(il8n), 1);

        // T5: scan loopback from phase 3
        do_reset();
        en = 1'b0; load = 1'b1; set_lp(3); tick();
        load = 1'b0; SE = 1'b1; SCANINPORT = 1'b0;
        so_exp = '{0, 0, 0, 0, 0, 1, 1, 1};
        for (int k = 0; k < 8; k++) begin
            check("t5.so", int'(so8), int'(so_exp[k]));
            tick();
        end
        SE = 1'b0;

        // T6: asynchronous reset between edges
        load = 1'b1; set_lp(11); tick();
        load = 1'b0; en = 1'b1;
        #2;
        r = 1'b1;
        #1;
        m8 = '0; m8n = '0; m3 = '0;
        check("t6.async", int'(g8), 0);
        check_all();
        r = 1'b0; en = 1'b0;
        tick();
        check("t6.hold", int'(ph8), 0);

        // W=3 sweep: six-state wrap
        do_reset();
        en = 1'b1; dir = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("w3.phase", int'(ph3), k % 6);
        end

        // Randomised traffic
        for (int c = 0; c < 800; c++) begin
            en = ($urandom_range(3) != 0);
            dir = $urandom_range(1);
            load = ($urandom_range(7) == 0);
            SE = ($urandom_range(9) == 0);
            SCANINPORT = $urandom_range(1);
            set_lp(int'($urandom_range(15)));
            tick();
            if ($urandom_range(63) == 0) begin
                #2;
                r = 1'b1;
                #1;
                m8 = '0; m8n = '0; m3 = '0;
                check_all();
                r = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
